// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: owns the shared ALU to run a shift-and-add unsigned multiply.
// While idle (or in the one-cycle DONE state) the datapath's operands and control
// pass straight through to the ALU. During a multiply the sequencer takes the ALU
// and issues one ADD per cycle until the multiplier bits are exhausted.
module alu_mul_sequencer #(
    parameter int WIDTH = 64,
    parameter int CNTW  = 7
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             ZeroFlag,
    output logic             Grant,
    input  logic [WIDTH-1:0] DpBusA,
    input  logic [WIDTH-1:0] DpBusB,
    input  logic [3:0]       DpCtrl,
    output logic [WIDTH-1:0] AluBusA,
    output logic [WIDTH-1:0] AluBusB,
    output logic [3:0]       AluCtrl,
    input  logic [WIDTH-1:0] AluBusW,
    input  logic             AluZero
);

    localparam logic [3:0] ALU_ADD = 4'b0010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           stateNext;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] prod;
    logic [CNTW-1:0]  count;
    logic             accept;
    logic             lastIter;

    // A request is taken whenever the ALU is not already in use by a multiply.
    assign accept = (state != RUN) && Start;

    // Stop once no set multiplier bits remain above the one consumed this cycle,
    // or after WIDTH iterations at most.
    assign lastIter = ((mplier >> 1) == '0) || (count == CNTW'(WIDTH - 1));

    // State register.
    always_ff @(posedge CLK or posedge Reset) begin
        // NOTE: every clocked assignment is non-blocking so all registers update
        // from the same pre-edge values.
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic: DONE accepts a new Start directly for back-to-back runs.
    always_comb begin
        // NOTE: default first so every path assigns stateNext and no latch forms.
        stateNext = state;
        case (state)
            IDLE:    stateNext = Start ? RUN : IDLE;
            RUN:     stateNext = lastIter ? DONE : RUN;
            DONE:    stateNext = Start ? RUN : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output logic: status flags and the ALU ownership mux.
    always_comb begin
        Busy    = 1'b0;
        Done    = 1'b0;
        Grant   = 1'b1;
        AluBusA = DpBusA;
        AluBusB = DpBusB;
        AluCtrl = DpCtrl;
        case (state)
            RUN: begin
                Busy    = 1'b1;
                Grant   = 1'b0;
                AluBusA = prod;
                AluBusB = mplier[0] ? mcand : '0;
                AluCtrl = ALU_ADD;
            end
            DONE: begin
                Done = 1'b1;
            end
            default: ;
        endcase
    end

    // Multiply datapath: load on accept, shift/accumulate in RUN, capture at the end.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
            count    <= '0;
            Result   <= '0;
            ZeroFlag <= 1'b0;
        end else if (accept) begin
            mcand  <= OpA;
            mplier <= OpB;
            prod   <= '0;
            count  <= '0;
        end else if (state == RUN) begin
            prod   <= AluBusW;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CNTW'(1);
            if (lastIter) begin
                Result   <= AluBusW;
                ZeroFlag <= AluZero;
            end
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: a behavioural ALU is attached to the
// Alu* ports, stimulus pushes expected products into a scoreboard queue, and a
// monitor pops and compares whenever Done pulses.
module tb_alu_mul_sequencer;

    localparam int WIDTH = 64;

    logic             CLK;
    logic             Reset;
    logic             Start;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic             ZeroFlag;
    logic             Grant;
    logic [WIDTH-1:0] DpBusA;
    logic [WIDTH-1:0] DpBusB;
    logic [3:0]       DpCtrl;
    logic [WIDTH-1:0] AluBusA;
    logic [WIDTH-1:0] AluBusB;
    logic [3:0]       AluCtrl;
    logic [WIDTH-1:0] AluBusW;
    logic             AluZero;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             zero;
        int               len;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   monOn  = 1'b0;
    int   runLen = 0;

    alu_mul_sequencer #(.WIDTH(WIDTH), .CNTW(7)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Start    (Start),
        .OpA      (OpA),
        .OpB      (OpB),
        .Busy     (Busy),
        .Done     (Done),
        .Result   (Result),
        .ZeroFlag (ZeroFlag),
        .Grant    (Grant),
        .DpBusA   (DpBusA),
        .DpBusB   (DpBusB),
        .DpCtrl   (DpCtrl),
        .AluBusA  (AluBusA),
        .AluBusB  (AluBusB),
        .AluCtrl  (AluCtrl),
        .AluBusW  (AluBusW),
        .AluZero  (AluZero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural ALU: AND/OR/ADD/SUB/PassB with a Zero flag.
    always_comb begin
        case (AluCtrl)
            4'b0000: AluBusW = AluBusA & AluBusB;
            4'b0001: AluBusW = AluBusA | AluBusB;
            4'b0010: AluBusW = AluBusA + AluBusB;
            4'b0110: AluBusW = AluBusA - AluBusB;
            4'b0111: AluBusW = AluBusB;
            default: AluBusW = '0;
        endcase
    end
    assign AluZero = (AluBusW == '0);

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected RUN length: one cycle for a zero multiplier, else top set bit index + 1.
    function automatic int expLen(input logic [WIDTH-1:0] b);
        int n = 1;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) n = i + 1;
        end
        return n;
    endfunction

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        logic [WIDTH-1:0] p;
        p      = a * b;
        e.res  = p;
        e.zero = (p == '0);
        e.len  = expLen(b);
        return e;
    endfunction

    // Monitor: compare against the scoreboard whenever Done pulses.
    always @(negedge CLK) begin
        if (monOn && !Reset) begin
            check("grant_vs_busy", {63'd0, Grant}, {63'd0, ~Busy});
            if (Busy) check("run_aluctrl", {60'd0, AluCtrl}, 64'd2);
            if (Done) begin
                check("done_not_busy", {63'd0, Busy}, 64'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", Result, e.res);
                    check("zeroflag", {63'd0, ZeroFlag}, {63'd0, e.zero});
                    check("run_length", 64'(runLen), 64'(e.len));
                end
            end
            if (Busy) runLen++;
            else      runLen = 0;
        end else begin
            runLen = 0;
        end
    end

    task automatic waitNotBusy();
        int n = 0;
        @(negedge CLK);
        while (Busy && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (Busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout actual=1 required=0");
        end
    endtask

    // Issue one multiply at a negedge; returns 1 time unit after the accepting edge.
    task automatic startMul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        waitNotBusy();
        OpA   = a;
        OpB   = b;
        Start = 1'b1;
        sb.push_back(model(a, b));
        @(posedge CLK);
        #1;
        Start = 1'b0;
        OpA   = {$urandom, $urandom};
        OpB   = {$urandom, $urandom};
    endtask

    task automatic waitDrained();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
            sb.delete();
        end
        @(negedge CLK);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] top;
        int               n;
        ones   = '1;
        top    = '0;
        top[WIDTH-1] = 1'b1;
        Reset  = 1'b0;
        Start  = 1'b0;
        OpA    = '0;
        OpB    = '0;
        DpCtrl = 4'b0110;
        DpBusA = 64'd10;
        DpBusB = 64'd3;

        // 1: reset asserted mid-cycle, outputs clear at once; then pass-through.
        #13 Reset = 1'b1;
        #1;
        check("rst_busy", {63'd0, Busy}, 64'd0);
        check("rst_done", {63'd0, Done}, 64'd0);
        check("rst_result", Result, 64'd0);
        check("rst_zero", {63'd0, ZeroFlag}, 64'd0);
        check("rst_grant", {63'd0, Grant}, 64'd1);
        @(negedge CLK);
        Reset = 1'b0;
        monOn = 1'b1;
        #1;
        check("idle_aluctrl", {60'd0, AluCtrl}, 64'h6);
        check("idle_alubusa", AluBusA, 64'd10);
        check("idle_alubusb", AluBusB, 64'd3);
        check("idle_alubusw", AluBusW, 64'd7);

        // 2: 6 x 7.
        startMul(64'd6, 64'd7);
        waitDrained();

        // 3: zero multiplier, then wrap to zero; Result holds across Start.
        startMul(64'd123, 64'd0);
        check("result_held_on_start", Result, 64'd42);
        waitDrained();
        startMul(top, 64'd2);
        waitDrained();

        // 4: all-ones squared takes the full WIDTH iterations.
        startMul(ones, ones);
        waitDrained();

        // 5: Start held high; second op launches from DONE, mid-run changes ignored.
        waitNotBusy();
        OpA   = 64'd6;
        OpB   = 64'd7;
        Start = 1'b1;
        sb.push_back(model(64'd6, 64'd7));
        @(posedge CLK);
        #1;
        OpA = 64'd9;
        OpB = 64'd3;
        n = 0;
        @(negedge CLK);
        while (!Done && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("b2b_done_seen", {63'd0, Done}, 64'd1);
        sb.push_back(model(64'd9, 64'd3));
        @(posedge CLK);
        #1;
        check("b2b_busy_after_done", {63'd0, Busy}, 64'd1);
        Start = 1'b0;
        waitDrained();

        // 6: reset two cycles into a long multiply aborts it silently.
        startMul(ones, ones);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        Reset = 1'b1;
        sb.delete();
        #1;
        check("abort_busy", {63'd0, Busy}, 64'd0);
        check("abort_grant", {63'd0, Grant}, 64'd1);
        check("abort_done", {63'd0, Done}, 64'd0);
        check("abort_result", Result, 64'd0);
        @(negedge CLK);
        Reset = 1'b0;
        repeat (80) @(negedge CLK);
        check("abort_result_after", Result, 64'd0);
        startMul(64'd5, 64'd5);
        waitDrained();

        // Randomised multiplies with assorted multiplier widths.
        for (int i = 0; i < 40; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 7) == 0) b = '0;
            startMul(a, b);
            waitDrained();
        end

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
